// File: rtl/fp_mul_pkg.sv
// Shared types, flag indices and the canonical-NaN helper for the iterative FP multiplier.
package fp_mul_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_NORM,
      S_ROUND,
      S_DONE
   } fp_state_t;

   typedef enum logic [1:0] {
      CLS_NORM,
      CLS_NAN,
      CLS_INF,
      CLS_ZERO
   } fp_cls_t;

   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_NX  = 0;

   localparam int FN_MAX_W = 128;

   // Quiet NaN with sign 0, all-ones exponent and only the fraction MSB set.
   function automatic logic [FN_MAX_W-1:0] canon_nan(input int exp_w, input int man_w);
      logic [FN_MAX_W-1:0] v;
      v = (((FN_MAX_W)'(1) << exp_w) - (FN_MAX_W)'(1)) << man_w;
      v = v | ((FN_MAX_W)'(1) << (man_w - 1));
      return v;
   endfunction

endpackage

// File: rtl/fp_mul_sig_core.sv
// Iterative shift-add significand multiplier: retires RADIX_BITS multiplier bits per cycle.
module fp_mul_sig_core
   import fp_mul_pkg::*;
#(
   parameter int SIG        = 24,
   parameter int RADIX_BITS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [SIG-1:0]     ma,
   input  logic [SIG-1:0]     mb,
   output logic               done,
   output logic [2*SIG-1:0]   prod
);

   localparam int ITER  = SIG / RADIX_BITS;
   localparam int CNT_W = $clog2(ITER + 1);

   logic               busy;
   logic [CNT_W-1:0]   cnt;
   logic [2*SIG-1:0]   mcand;
   logic [SIG-1:0]     mplier;
   logic [2*SIG-1:0]   acc;
   logic [2*SIG-1:0]   pp;

   assign pp   = mcand * {{(2*SIG-RADIX_BITS){1'b0}}, mplier[RADIX_BITS-1:0]};
   // High during the final iteration cycle; prod is complete after that edge.
   assign done = busy && (cnt == CNT_W'(1));
   assign prod = acc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= CNT_W'(ITER);
         mcand  <= {{SIG{1'b0}}, ma};
         mplier <= mb;
         acc    <= '0;
      end else if (busy) begin
         acc    <= acc + pp;
         mcand  <= mcand << RADIX_BITS;
         mplier <= mplier >> RADIX_BITS;
         cnt    <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/fp_mul_iter.sv
// Multi-cycle IEEE-754 multiplier with RNE rounding, special values and exception flags.
// Optional FP_MUL_STICKY_FLAGS_EN adds flags_clr / flags_sticky accumulation.
//
// state   | meaning
// IDLE    | in_ready high, waiting for operands
// MUL     | iterative significand multiply (ITER cycles)
// NORM    | normalise product, form guard and sticky
// ROUND   | round-to-nearest-even, range checks, build result
// DONE    | out_valid high, result held until out_ready
module fp_mul_iter
   import fp_mul_pkg::*;
#(
   parameter int EXP_W      = 8,
   parameter int MAN_W      = 23,
   parameter int RADIX_BITS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MAN_W:0]     a,
   input  logic [EXP_W+MAN_W:0]     b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     result,
   output logic [3:0]               flags
`ifdef FP_MUL_STICKY_FLAGS_EN
   ,
   input  logic                     flags_clr,
   output logic [3:0]               flags_sticky
`endif
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int SIG  = MAN_W + 1;
   localparam int EW2  = EXP_W + 2;
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam logic signed [EW2-1:0] BIAS_S   = EW2'(BIAS);
   localparam logic signed [EW2-1:0] EMAX_S   = EW2'((1 << EXP_W) - 1);
   localparam logic [FN_MAX_W-1:0]   NAN_FULL = canon_nan(EXP_W, MAN_W);
   localparam logic [W-2:0]          INF_MAG  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

   fp_state_t state;

   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
   fp_cls_t          cls_in;
   logic signed [EW2-1:0] e_sum;
   logic             accept;

   assign ea = a[W-2 -: EXP_W];
   assign eb = b[W-2 -: EXP_W];
   assign fa = a[MAN_W-1:0];
   assign fb = b[MAN_W-1:0];

   assign a_nan  = (&ea) && (|fa);
   assign a_inf  = (&ea) && !(|fa);
   assign a_zero = !(|ea);
   assign b_nan  = (&eb) && (|fb);
   assign b_inf  = (&eb) && !(|fb);
   assign b_zero = !(|eb);

   // Subnormals land in the zero class, which is how they are flushed.
   always_comb begin
      cls_in = CLS_NORM;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) cls_in = CLS_NAN;
      else if (a_inf || b_inf)                                      cls_in = CLS_INF;
      else if (a_zero || b_zero)                                    cls_in = CLS_ZERO;
   end

   assign e_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
   assign accept = (state == S_IDLE) && in_valid && in_ready;

   logic               core_done;
   logic [2*SIG-1:0]   prod;

   fp_mul_sig_core #(
      .SIG        (SIG),
      .RADIX_BITS (RADIX_BITS)
   ) u_sig_core (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept),
      .ma    ({|ea, fa}),
      .mb    ({|eb, fb}),
      .done  (core_done),
      .prod  (prod)
   );

   // Product lies in [1,4); sh drops the leading one and aligns the fraction at the top.
   logic               hi;
   logic [2*SIG-2:0]   sh;
   logic [MAN_W-1:0]   frac_n;
   logic               guard_n, sticky_n;

   assign hi       = prod[2*SIG-1];
   assign sh       = hi ? prod[2*SIG-2:0] : {prod[2*SIG-3:0], 1'b0};
   assign frac_n   = sh[2*SIG-2 -: MAN_W];
   assign guard_n  = sh[SIG-1];
   assign sticky_n = |sh[SIG-2:0];

   logic                  sign_r;
   logic signed [EW2-1:0] exp_r;
   fp_cls_t               cls_r;
   logic [MAN_W-1:0]      frac_r;
   logic                  guard_r, sticky_r;

   logic                  round_up;
   logic [MAN_W:0]        frac_rnd;
   logic signed [EW2-1:0] exp_fin;
   logic                  ovf, unf;
   logic [W-1:0]          res_n;
   logic [3:0]            flg_n;

   assign round_up = guard_r && (sticky_r || frac_r[0]);
   assign frac_rnd = {1'b0, frac_r} + {{MAN_W{1'b0}}, round_up};
   // A carry out of rounding leaves an all-zero fraction, so only the exponent moves.
   assign exp_fin  = exp_r + $signed({{(EW2-1){1'b0}}, frac_rnd[MAN_W]});
   assign ovf      = !exp_fin[EW2-1] && (exp_fin >= EMAX_S);
   assign unf      = exp_fin[EW2-1] || (exp_fin == '0);

   always_comb begin
      res_n = '0;
      flg_n = '0;
      case (cls_r)
         CLS_NAN: begin
            res_n          = NAN_FULL[W-1:0];
            flg_n[FLG_INV] = 1'b1;
         end
         CLS_INF:  res_n = {sign_r, INF_MAG};
         CLS_ZERO: res_n = {sign_r, {(W-1){1'b0}}};
         default: begin
            if (ovf) begin
               res_n          = {sign_r, INF_MAG};
               flg_n[FLG_OVF] = 1'b1;
               flg_n[FLG_NX]  = 1'b1;
            end else if (unf) begin
               res_n          = {sign_r, {(W-1){1'b0}}};
               flg_n[FLG_UNF] = 1'b1;
               flg_n[FLG_NX]  = 1'b1;
            end else begin
               res_n          = {sign_r, exp_fin[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
               flg_n[FLG_NX]  = guard_r || sticky_r;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
         sign_r    <= 1'b0;
         exp_r     <= '0;
         cls_r     <= CLS_NORM;
         frac_r    <= '0;
         guard_r   <= 1'b0;
         sticky_r  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state    <= S_MUL;
                  in_ready <= 1'b0;
                  sign_r   <= a[W-1] ^ b[W-1];
                  exp_r    <= e_sum;
                  cls_r    <= cls_in;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            S_MUL: begin
               if (core_done) state <= S_NORM;
            end
            S_NORM: begin
               frac_r   <= frac_n;
               guard_r  <= guard_n;
               sticky_r <= sticky_n;
               exp_r    <= exp_r + $signed({{(EW2-1){1'b0}}, hi});
               state    <= S_ROUND;
            end
            S_ROUND: begin
               result    <= res_n;
               flags     <= flg_n;
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef FP_MUL_STICKY_FLAGS_EN
   // Clear wins over a same-cycle handshake; that result's flags are lost.
   always_ff @(posedge clk) begin
      if (!rst_n)                      flags_sticky <= '0;
      else if (flags_clr)              flags_sticky <= '0;
      else if (out_valid && out_ready) flags_sticky <= flags_sticky | flags;
   end
`endif

endmodule

// File: tb/tb_fp_mul_iter.sv
// Self-checking bench for fp_mul_iter (single precision, defaults) with a result scoreboard.
module tb_fp_mul_iter;

   localparam int LAT = 24 / 4 + 2;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [35:0] want;
   } vec_t;

   localparam vec_t DIR [15] = '{
      '{32'h3FC00000, 32'h40000000, {4'b0000, 32'h40400000}},
      '{32'h3F800001, 32'h3F800001, {4'b0001, 32'h3F800002}},
      '{32'h7F800000, 32'h00000000, {4'b1000, 32'h7FC00000}},
      '{32'hFFC00001, 32'h3F800000, {4'b1000, 32'h7FC00000}},
      '{32'h7F000000, 32'h7F000000, {4'b0101, 32'h7F800000}},
      '{32'h00800000, 32'h00800000, {4'b0011, 32'h00000000}},
      '{32'hBF800000, 32'h3F800000, {4'b0000, 32'hBF800000}},
      '{32'h00000001, 32'h3F800000, {4'b0000, 32'h00000000}},
      '{32'hFF800000, 32'h40000000, {4'b0000, 32'hFF800000}},
      '{32'h80000000, 32'h3F800000, {4'b0000, 32'h80000000}},
      '{32'h3FFFFFFF, 32'h3FFFFFFF, {4'b0001, 32'h407FFFFE}},
      '{32'h3FFFFFFE, 32'h3F800001, {4'b0001, 32'h40000000}},
      '{32'h7F000000, 32'h40000000, {4'b0101, 32'h7F800000}},
      '{32'h00800000, 32'h3F800000, {4'b0000, 32'h00800000}},
      '{32'h00800000, 32'h3F000000, {4'b0011, 32'h00000000}}
   };

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  flags;
`ifdef FP_MUL_STICKY_FLAGS_EN
   logic        flags_clr;
   logic [3:0]  flags_sticky;
   logic [3:0]  sticky_model;
`endif

   int n_chk;
   int n_err;
   logic [35:0] exp_q [$];

   fp_mul_iter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
`ifdef FP_MUL_STICKY_FLAGS_EN
      ,
      .flags_clr    (flags_clr),
      .flags_sticky (flags_sticky)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Integer reference: exact 48-bit product, RNE via remainder against the half-ulp.
   function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      int ex, ey, e, sh;
      logic s, nx, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
      longint unsigned mx, my, p, q, rem, half;
      logic [7:0] e8;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      x_nan  = (ex == 255) && (x[22:0] != 0);
      y_nan  = (ey == 255) && (y[22:0] != 0);
      x_inf  = (ex == 255) && (x[22:0] == 0);
      y_inf  = (ey == 255) && (y[22:0] == 0);
      x_zero = (ex == 0);
      y_zero = (ey == 0);
      s = x[31] ^ y[31];
      if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) return {4'b1000, 32'h7FC00000};
      if (x_inf || y_inf) return {4'b0000, s, 31'h7F800000};
      if (x_zero || y_zero) return {4'b0000, s, 31'h0};
      mx = 64'({1'b1, x[22:0]});
      my = 64'({1'b1, y[22:0]});
      p  = mx * my;
      e  = ex + ey - 127;
      if (p[47]) begin
         sh = 24;
         e  = e + 1;
      end else begin
         sh = 23;
      end
      q    = p >> sh;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      nx   = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q[24]) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return {4'b0101, s, 31'h7F800000};
      if (e <= 0) return {4'b0011, s, 31'h0};
      e8 = e[7:0];
      return {3'b000, nx, s, e8, q[22:0]};
   endfunction

   // Scoreboard: compare every output handshake against the oldest expectation.
   always @(negedge clk) begin
      logic [35:0] w;
      if (rst_n && out_valid && out_ready) begin
         chk("sb_pending", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("result", 64'(result), 64'(w[31:0]));
            chk("flags", 64'(flags), 64'(w[35:32]));
`ifdef FP_MUL_STICKY_FLAGS_EN
            sticky_model = sticky_model | w[35:32];
`endif
         end
      end
   end

   task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic [35:0] want);
      int n;
      a = x;
      b = y;
      in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept", 64'(in_ready), 64'(1));
      exp_q.push_back(want);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("busy_in_ready", 64'(in_ready), 64'(0));
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 64'(n), 64'(LAT));
   endtask

   task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [35:0] want);
      start_op(x, y, want);
      @(posedge clk); #1;
      chk("idle_in_ready", 64'(in_ready), 64'(1));
      chk("out_valid_drop", 64'(out_valid), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] x, y;
      logic [31:0] hold_r;
      logic [3:0]  hold_f;
      int          n_ov;

      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      out_ready = 1'b1;
`ifdef FP_MUL_STICKY_FLAGS_EN
      flags_clr = 1'b0;
      sticky_model = '0;
`endif

      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = 32'h3F800000;
      b = 32'h3F800000;
      @(posedge clk); #1;
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_result", 64'(result), 64'(0));
      chk("rst_flags", 64'(flags), 64'(0));
`ifdef FP_MUL_STICKY_FLAGS_EN
      chk("rst_sticky", 64'(flags_sticky), 64'(0));
`endif
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_in_ready", 64'(in_ready), 64'(1));

      for (int i = 0; i < 15; i++) do_op(DIR[i].a, DIR[i].b, DIR[i].want);

      for (int i = 0; i < 12; i++) begin
         x = $urandom;
         y = $urandom;
         if (i < 6) begin
            x[30:23] = 8'($urandom_range(90, 164));
            y[30:23] = 8'($urandom_range(90, 164));
         end else begin
            x[30:23] = 8'($urandom_range(1, 254));
            y[30:23] = 8'($urandom_range(1, 254));
         end
         do_op(x, y, ref_mul(x, y));
      end

      // Backpressure: result held, new operands ignored while DONE waits.
      out_ready = 1'b0;
      start_op(32'h40490FDB, 32'h3FB504F3, ref_mul(32'h40490FDB, 32'h3FB504F3));
      hold_r = result;
      hold_f = flags;
      a = 32'h40000000;
      b = 32'h40000000;
      in_valid = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_valid", 64'(out_valid), 64'(1));
         chk("bp_result", 64'(result), 64'(hold_r));
         chk("bp_flags", 64'(flags), 64'(hold_f));
         chk("bp_in_ready", 64'(in_ready), 64'(0));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_rel_in_ready", 64'(in_ready), 64'(1));
      chk("bp_rel_out_valid", 64'(out_valid), 64'(0));

`ifdef FP_MUL_STICKY_FLAGS_EN
      chk("sticky_acc", 64'(flags_sticky), 64'(sticky_model));
      flags_clr = 1'b1;
      @(posedge clk); #1;
      flags_clr = 1'b0;
      sticky_model = '0;
      chk("sticky_clr", 64'(flags_sticky), 64'(0));
      do_op(32'h3F800001, 32'h3F800001, {4'b0001, 32'h3F800002});
      chk("sticky_nx", 64'(flags_sticky), 64'(4'b0001));
      out_ready = 1'b0;
      start_op(32'h7F000000, 32'h7F000000, {4'b0101, 32'h7F800000});
      flags_clr = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      flags_clr = 1'b0;
      sticky_model = '0;
      chk("sticky_clr_prio", 64'(flags_sticky), 64'(0));
      do_op(32'h00800000, 32'h00800000, {4'b0011, 32'h00000000});
      chk("sticky_unf", 64'(flags_sticky), 64'(sticky_model));
`endif

      // Reset during the third MUL iteration: the operation must vanish.
      a = 32'h3FC00000;
      b = 32'h40000000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_in_ready", 64'(in_ready), 64'(0));
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_rel_in_ready", 64'(in_ready), 64'(1));
`ifdef FP_MUL_STICKY_FLAGS_EN
      chk("midrst_sticky", 64'(flags_sticky), 64'(0));
      sticky_model = '0;
`endif
      n_ov = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (out_valid) n_ov++;
      end
      chk("midrst_no_output", 64'(n_ov), 64'(0));

      do_op(32'h3FC00000, 32'h40000000, {4'b0000, 32'h40400000});
      chk("drain", 64'(exp_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
